steer_sequencer: RTL and testbench

Rider-detection and steering-enable sequencer that configures the balance controller. It samples left/right load-cell readings and derives the signed load difference and total rider weight. A three-state machine with a settling timer drives `rider_off` and `en_steer`, so steering only engages once a rider has stood balanced for ~1.34 s. It sits between the load-cell A2D interface and the balance controller.

---
 rtl/segway_pkg.sv | 37 +++
 rtl/settle_tmr.sv | 38 +++
 rtl/steer_sequencer.sv | 161 ++++++++++++++++
 tb/tb_steer_sequencer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/segway_pkg.sv
// -----------------------------------------------------------------------------
// segway_pkg
// Shared types and constants for the rider-detection / steering-enable logic.
//   steer_state_t : sequencer states (IDLE, WAIT, STEER)
//   TMR_W_FULL    : settling timer width for silicon (~1.34 s at 50 MHz)
//   TMR_W_FAST    : settling timer width for simulation
//   MIN_RIDER_WT  : default rider-present threshold on the load sum
//   WT_HYST       : default hysteresis around MIN_RIDER_WT
//   sat12()       : clamp a 13-bit signed value into 12-bit signed range
// -----------------------------------------------------------------------------
package segway_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    WAIT  = 2'b01,
    STEER = 2'b10
  } steer_state_t;

  localparam int TMR_W_FULL = 26;
  localparam int TMR_W_FAST = 15;

  localparam logic [11:0] MIN_RIDER_WT = 12'h200;
  localparam logic [7:0]  WT_HYST      = 8'h40;

  // Bits 12 and 11 disagree exactly when the value does not fit in 12 bits;
  // the sign bit then picks the rail.
  function automatic logic [11:0] sat12(input logic [12:0] d);
    logic [11:0] res;
    if (d[12] != d[11]) begin
      res = d[12] ? 12'h800 : 12'h7FF;
    end else begin
      res = d[11:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/settle_tmr.sv
// -----------------------------------------------------------------------------
// settle_tmr
// Saturating up-counter used to time how long a rider has stood balanced.
// Parameters:
//   W        : counter width
// Ports:
//   clk      in  1  system clock
//   rst      in  1  asynchronous active-high reset (counter -> 0)
//   clr_tmr  in  1  synchronous clear, takes effect at the next edge
//   tmr_full out 1  counter is all ones (it holds there, never wraps)
// -----------------------------------------------------------------------------
module settle_tmr #(
  parameter int W = 26
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_tmr,
  output logic tmr_full
);

  logic [W-1:0] cnt_r;

  assign tmr_full = &cnt_r;

  // Counter register: clear wins, otherwise count up and stick at all ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (clr_tmr) begin
      cnt_r <= '0;
    end else if (!tmr_full) begin
      cnt_r <= cnt_r + {{(W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/steer_sequencer.sv
// -----------------------------------------------------------------------------
// steer_sequencer
// Samples left/right load cells, derives the saturated signed load difference
// and the total rider weight, and sequences rider_off / en_steer so steering
// only engages after the rider has stood balanced for a full timer interval.
// Parameters:
//   fast_sim      : nonzero shrinks the settling timer to TMR_W_FAST bits
//   MIN_RIDER_WT  : rider-present threshold on the load sum
//   WT_HYST       : hysteresis around MIN_RIDER_WT
// Ports:
//   clk           in  1   system clock (50 MHz)
//   rst           in  1   asynchronous active-high reset
//   vld           in  1   strobe: lft_ld / rght_ld carry new readings
//   lft_ld        in  12  left load cell, unsigned
//   rght_ld       in  12  right load cell, unsigned
//   ld_cell_diff  out 12  saturated signed lft - rght, registered
//   rider_off     out 1   no rider present, registered
//   en_steer      out 1   steering enabled, registered
// -----------------------------------------------------------------------------
module steer_sequencer
  import segway_pkg::*;
#(
  parameter int          fast_sim     = 0,
  parameter logic [11:0] MIN_RIDER_WT = segway_pkg::MIN_RIDER_WT,
  parameter logic [7:0]  WT_HYST      = segway_pkg::WT_HYST
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vld,
  input  logic [11:0] lft_ld,
  input  logic [11:0] rght_ld,
  output logic [11:0] ld_cell_diff,
  output logic        rider_off,
  output logic        en_steer
);

  localparam int TMR_W = (fast_sim != 0) ? TMR_W_FAST : TMR_W_FULL;

  // Thresholds are formed at 13 bits so the comparisons never overflow.
  localparam logic [12:0] THR_HI = {1'b0, MIN_RIDER_WT} + {5'b0_0000, WT_HYST};
  localparam logic [12:0] THR_LO = {1'b0, MIN_RIDER_WT} - {5'b0_0000, WT_HYST};

  logic [11:0]  lft_q_r;
  logic [11:0]  rght_q_r;
  logic [12:0]  sum_s;
  logic [12:0]  diff_s;
  logic [12:0]  abs_diff_s;
  logic         sum_gt_min_s;
  logic         sum_lt_min_s;
  logic         diff_gt_1_4_s;
  logic         diff_gt_15_16_s;
  logic         tmr_full_s;
  logic         clr_tmr_s;
  steer_state_t state_r;
  steer_state_t next_state_s;
  logic [11:0]  ld_cell_diff_r;
  logic         rider_off_r;
  logic         en_steer_r;

  // Holding registers for the most recent valid load-cell samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lft_q_r  <= 12'h000;
      rght_q_r <= 12'h000;
    end else if (vld) begin
      lft_q_r  <= lft_ld;
      rght_q_r <= rght_ld;
    end else begin
      lft_q_r  <= lft_q_r;
      rght_q_r <= rght_q_r;
    end
  end

  assign sum_s      = {1'b0, lft_q_r} + {1'b0, rght_q_r};
  assign diff_s     = {1'b0, lft_q_r} - {1'b0, rght_q_r};
  // |diff| peaks at 4095, so negating the 13-bit value is always exact.
  assign abs_diff_s = diff_s[12] ? (13'd0 - diff_s) : diff_s;

  assign sum_gt_min_s    = (sum_s > THR_HI);
  assign sum_lt_min_s    = (sum_s < THR_LO);
  assign diff_gt_1_4_s   = (abs_diff_s > (sum_s >> 2));
  assign diff_gt_15_16_s = (abs_diff_s > (sum_s - (sum_s >> 4)));

  settle_tmr #(
    .W (TMR_W)
  ) u_settle_tmr (
    .clk      (clk),
    .rst      (rst),
    .clr_tmr  (clr_tmr_s),
    .tmr_full (tmr_full_s)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state and timer-clear decode; rider loss always takes priority.
  always_comb begin
    next_state_s = state_r;
    clr_tmr_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (sum_gt_min_s) begin
          next_state_s = WAIT;
          clr_tmr_s    = 1'b1;
        end else begin
          next_state_s = IDLE;
        end
      end
      WAIT: begin
        if (sum_lt_min_s) begin
          next_state_s = IDLE;
        end else if (diff_gt_1_4_s) begin
          next_state_s = WAIT;
          clr_tmr_s    = 1'b1;
        end else if (tmr_full_s) begin
          next_state_s = STEER;
        end else begin
          next_state_s = WAIT;
        end
      end
      STEER: begin
        if (sum_lt_min_s) begin
          next_state_s = IDLE;
        end else if (diff_gt_15_16_s) begin
          next_state_s = WAIT;
          clr_tmr_s    = 1'b1;
        end else begin
          next_state_s = STEER;
        end
      end
      default: begin
        next_state_s = IDLE;
        clr_tmr_s    = 1'b0;
      end
    endcase
  end

  // Output registers: flags decoded from the next state, diff from the held samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_cell_diff_r <= 12'h000;
      rider_off_r    <= 1'b1;
      en_steer_r     <= 1'b0;
    end else begin
      ld_cell_diff_r <= sat12(diff_s);
      rider_off_r    <= (next_state_s == IDLE);
      en_steer_r     <= (next_state_s == STEER);
    end
  end

  assign ld_cell_diff = ld_cell_diff_r;
  assign rider_off    = rider_off_r;
  assign en_steer     = en_steer_r;

endmodule

// File: tb/tb_steer_sequencer.sv
// -----------------------------------------------------------------------------
// tb_steer_sequencer
// Scoreboard bench: the driver advances a behavioural rider model one clock at
// a time and queues the outputs expected after each edge; an independent
// monitor pops and compares them shortly after every rising edge.
// -----------------------------------------------------------------------------
module tb_steer_sequencer;

  localparam int TMR_MAX = (1 << 15) - 1;   // fast_sim timer terminal count
  localparam int SUM_HI  = 'h240;           // 0x200 + 0x40
  localparam int SUM_LO  = 'h1C0;           // 0x200 - 0x40

  logic        clk = 1'b0;
  logic        rst;
  logic        vld;
  logic [11:0] lft_ld;
  logic [11:0] rght_ld;
  logic [11:0] ld_cell_diff;
  logic        rider_off;
  logic        en_steer;

  steer_sequencer #(
    .fast_sim (1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .vld          (vld),
    .lft_ld       (lft_ld),
    .rght_ld      (rght_ld),
    .ld_cell_diff (ld_cell_diff),
    .rider_off    (rider_off),
    .en_steer     (en_steer)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        ro;
    logic        es;
    logic [11:0] ld;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;

  // Behavioural rider model: phase of the ride plus cycles since timer restart.
  typedef enum {P_OFF, P_SETTLE, P_STEER} phase_t;
  phase_t m_phase;
  int     m_lft;
  int     m_rght;
  int     m_cnt;

  task automatic check(input string name, input int act, input int exp_v);
    n_tests++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp_v, $time);
    end
  endtask

  function automatic logic [11:0] ref_diff(input int l, input int r);
    int d;
    d = l - r;
    if (d > 2047) d = 2047;
    else if (d < -2048) d = -2048;
    return 12'(d);
  endfunction

  task automatic model_reset();
    m_phase = P_OFF;
    m_lft   = 0;
    m_rght  = 0;
    m_cnt   = 0;
  endtask

  // One clock edge of the model; decisions use the samples held before it.
  task automatic model_edge(input bit v, input int l, input int r);
    int   sum;
    int   ad;
    bit   full;
    bit   restart;
    exp_t e;
    sum     = m_lft + m_rght;
    ad      = (m_lft > m_rght) ? (m_lft - m_rght) : (m_rght - m_lft);
    full    = (m_cnt >= TMR_MAX);
    restart = 1'b0;
    e.ld    = ref_diff(m_lft, m_rght);
    case (m_phase)
      P_OFF: begin
        if (sum > SUM_HI) begin
          m_phase = P_SETTLE;
          restart = 1'b1;
        end
      end
      P_SETTLE: begin
        if (sum < SUM_LO) m_phase = P_OFF;
        else if (ad > sum / 4) restart = 1'b1;
        else if (full) m_phase = P_STEER;
      end
      default: begin
        if (sum < SUM_LO) m_phase = P_OFF;
        else if (ad > sum - sum / 16) begin
          m_phase = P_SETTLE;
          restart = 1'b1;
        end
      end
    endcase
    m_cnt = restart ? 0 : ((m_cnt < TMR_MAX) ? m_cnt + 1 : m_cnt);
    e.ro  = (m_phase == P_OFF);
    e.es  = (m_phase == P_STEER);
    if (v) begin
      m_lft  = l;
      m_rght = r;
    end
    sb_q.push_back(e);
  endtask

  task automatic step(input bit v, input int l, input int r);
    vld     = v;
    lft_ld  = 12'(l);
    rght_ld = 12'(r);
    @(posedge clk);
    model_edge(v, l, r);
    #2;
  endtask

  task automatic run(input int n, input int l, input int r);
    for (int i = 0; i < n; i++) step(1'b1, l, r);
  endtask

  // Monitor: compare the DUT against every queued expectation.
  always @(posedge clk) begin
    #1;
    if (sb_q.size() != 0) begin
      mon_e = sb_q.pop_front();
      check("rider_off",    int'(rider_off),    int'(mon_e.ro));
      check("en_steer",     int'(en_steer),     int'(mon_e.es));
      check("ld_cell_diff", int'(ld_cell_diff), int'(mon_e.ld));
    end
  end

  initial begin
    rst     = 1'b1;
    vld     = 1'b0;
    lft_ld  = 12'h000;
    rght_ld = 12'h000;
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    check("reset_rider_off", int'(rider_off),    1);
    check("reset_en_steer",  int'(en_steer),     0);
    check("reset_ld_diff",   int'(ld_cell_diff), 0);
    rst = 1'b0;

    // Saturation at both rails, then drop back to no rider.
    step(1'b1, 'hFFF, 'h000);
    step(1'b0, 'h000, 'h000);
    step(1'b1, 'h000, 'hFFF);
    step(1'b0, 'h000, 'h000);
    run(3, 'h000, 'h000);

    // Hysteresis from IDLE: 0x1D0, 0x230 and exactly 0x240 all hold; 0x241 mounts.
    run(3, 'h0E8, 'h0E8);
    run(3, 'h118, 'h118);
    run(3, 'h120, 'h120);
    run(2, 'h121, 'h120);
    run(3, 'h000, 'h000);

    // Balanced mount and full settling interval to STEER.
    run(TMR_MAX + 10, 'h180, 'h180);

    // In STEER: 0x1D0 keeps steering, step-off returns to WAIT, 0x1B0 drops out.
    run(5, 'h0E8, 'h0E8);
    run(3, 'h400, 'h010);
    run(3, 'h0D8, 'h0D8);

    // Unbalanced hold keeps the timer cleared, then rebalance and engage again.
    for (int i = 0; i < 200; i++) step(1'($urandom_range(0, 1)), 'h300, 'h080);
    run(TMR_MAX + 10, 'h1C0, 'h1C0);

    // Mild imbalance while steering, then asynchronous reset mid-STEER.
    run(4, 'h1A0, 'h160);
    rst = 1'b1;
    #1;
    check("async_rst_rider_off", int'(rider_off),    1);
    check("async_rst_en_steer",  int'(en_steer),     0);
    check("async_rst_ld_diff",   int'(ld_cell_diff), 0);
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;

    // Randomised loads around the thresholds with sparse vld.
    for (int i = 0; i < 600; i++) begin
      int l;
      int r;
      if ($urandom_range(0, 7) == 0) begin
        l = int'($urandom_range(0, 'hFFF));
        r = int'($urandom_range(0, 'hFFF));
      end else begin
        l = int'($urandom_range('h0A0, 'h180));
        r = int'($urandom_range('h0A0, 'h180));
      end
      step(1'($urandom_range(0, 3) != 0), l, r);
    end

    step(1'b0, 'h000, 'h000);
    @(posedge clk);
    #3;
    check("scoreboard_drained", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
